// File: rtl/dom_gf2_unmask_monitor.sv
// Recombines the d output shares of a pipelined masked GF(2^2) gadget and checks
// each plain result against a golden value delayed by the gadget latency.
module dom_gf2_unmask_monitor #(
  parameter int unsigned SHARES      = 2,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  ClkxCI,
  input  logic                  RstxBI,
  input  logic                  StartxSI,
  input  logic                  ClearxSI,
  input  logic                  InValidxSI,
  input  logic [1:0]            ExpxDI,
  input  logic [2*SHARES-1:0]   _QxDI,
  output logic [1:0]            QxDO,
  output logic                  OutValidxSO,
  output logic                  MismatchxSO,
  output logic [CNT_W-1:0]      ErrCntxDO,
  output logic [CNT_W-1:0]      ChkCntxDO,
  output logic [CNT_W-1:0]      FirstErrIdxxDO,
  output logic                  FirstErrValidxSO,
  output logic                  BusyxSO,
  output logic                  DonexSO
);

  localparam int unsigned AW = $clog2(NUM_VECTORS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            acc_q, acc_d;
  logic [LATENCY-1:0]       dl_vld_q, dl_vld_d;
  logic [LATENCY-1:0][1:0]  dl_exp_q, dl_exp_d;
  logic [1:0]               q_q, q_d;
  logic                     ov_q, ov_d;
  logic                     mm_q, mm_d;
  logic [CNT_W-1:0]         err_q, err_d;
  logic [CNT_W-1:0]         chk_q, chk_d;
  logic [CNT_W-1:0]         fei_q, fei_d;
  logic                     fev_q, fev_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [1:0]               q_rec;
  logic                     pend;
  logic                     cmp;
  logic                     accept;
  logic                     start_ok;

  // Share recombination and in-flight tracking (all stages except the compare stage)
  always_comb begin
    q_rec = 2'b00;
    for (int i = 0; i < int'(SHARES); i++) begin
      q_rec = q_rec ^ _QxDI[2*i +: 2];
    end
    pend = 1'b0;
    for (int i = 0; i < int'(LATENCY) - 1; i++) begin
      pend = pend | dl_vld_q[i];
    end
  end

  assign cmp      = dl_vld_q[LATENCY-1];
  assign accept   = (state_q == RUN) && InValidxSI;
  assign start_ok = StartxSI && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    q_d         = q_q;
    ov_d        = 1'b0;
    mm_d        = 1'b0;
    err_d       = err_q;
    chk_d       = chk_q;
    fei_d       = fei_q;
    fev_d       = fev_q;
    dl_vld_d[0] = accept;
    dl_exp_d[0] = ExpxDI;
    for (int i = 1; i < int'(LATENCY); i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_exp_d[i] = dl_exp_q[i-1];
    end

    if (ClearxSI) begin
      state_d  = IDLE;
      acc_d    = '0;
      dl_vld_d = '0;
      err_d    = '0;
      chk_d    = '0;
      fei_d    = '0;
      fev_d    = 1'b0;
    end else begin
      if (cmp) begin
        q_d   = q_rec;
        ov_d  = 1'b1;
        mm_d  = (q_rec != dl_exp_q[LATENCY-1]);
        chk_d = chk_q + CNT_W'(1);
        if (q_rec != dl_exp_q[LATENCY-1]) begin
          if (err_q != {CNT_W{1'b1}}) begin
            err_d = err_q + CNT_W'(1);
          end
          if (!fev_q) begin
            fei_d = chk_q;
            fev_d = 1'b1;
          end
        end
      end

      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            state_d = RUN;
            acc_d   = '0;
            err_d   = '0;
            chk_d   = '0;
            fei_d   = '0;
            fev_d   = 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            acc_d = acc_q + AW'(1);
            if (acc_q == AW'(NUM_VECTORS - 1)) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cmp && !pend) begin
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      dl_vld_q <= '0;
      dl_exp_q <= '0;
      q_q      <= '0;
      ov_q     <= 1'b0;
      mm_q     <= 1'b0;
      err_q    <= '0;
      chk_q    <= '0;
      fei_q    <= '0;
      fev_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      dl_vld_q <= dl_vld_d;
      dl_exp_q <= dl_exp_d;
      q_q      <= q_d;
      ov_q     <= ov_d;
      mm_q     <= mm_d;
      err_q    <= err_d;
      chk_q    <= chk_d;
      fei_q    <= fei_d;
      fev_q    <= fev_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign QxDO             = q_q;
  assign OutValidxSO      = ov_q;
  assign MismatchxSO      = mm_q;
  assign ErrCntxDO        = err_q;
  assign ChkCntxDO        = chk_q;
  assign FirstErrIdxxDO   = fei_q;
  assign FirstErrValidxSO = fev_q;
  assign BusyxSO          = busy_q;
  assign DonexSO          = done_q;

endmodule

// File: tb/tb_dom_gf2_unmask_monitor.sv
// Directed bench for dom_gf2_unmask_monitor: three parameterisations share one clock
// and reset, each exercised in turn with hand-computed expectations.
module tb_dom_gf2_unmask_monitor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // A: SHARES=2, LATENCY=1, NUM_VECTORS=4, CNT_W=16
  logic a_start, a_clear, a_inv;
  logic [1:0] a_exp, a_qo;
  logic [3:0] a_q;
  logic a_ov, a_mm, a_fev, a_busy, a_done;
  logic [15:0] a_err, a_chk, a_fei;

  // B: SHARES=2, LATENCY=1, NUM_VECTORS=3, CNT_W=2
  logic b_start, b_clear, b_inv;
  logic [1:0] b_exp, b_qo;
  logic [3:0] b_q;
  logic b_ov, b_mm, b_fev, b_busy, b_done;
  logic [1:0] b_err, b_chk, b_fei;

  // C: SHARES=3, LATENCY=3, NUM_VECTORS=2, CNT_W=8
  logic c_start, c_clear, c_inv;
  logic [1:0] c_exp, c_qo;
  logic [5:0] c_q;
  logic c_ov, c_mm, c_fev, c_busy, c_done;
  logic [7:0] c_err, c_chk, c_fei;

  dom_gf2_unmask_monitor #(.SHARES(2), .LATENCY(1), .NUM_VECTORS(4), .CNT_W(16)) u_a (
    .ClkxCI(clk), .RstxBI(rst_n), .StartxSI(a_start), .ClearxSI(a_clear),
    .InValidxSI(a_inv), .ExpxDI(a_exp), ._QxDI(a_q), .QxDO(a_qo),
    .OutValidxSO(a_ov), .MismatchxSO(a_mm), .ErrCntxDO(a_err), .ChkCntxDO(a_chk),
    .FirstErrIdxxDO(a_fei), .FirstErrValidxSO(a_fev), .BusyxSO(a_busy), .DonexSO(a_done)
  );

  dom_gf2_unmask_monitor #(.SHARES(2), .LATENCY(1), .NUM_VECTORS(3), .CNT_W(2)) u_b (
    .ClkxCI(clk), .RstxBI(rst_n), .StartxSI(b_start), .ClearxSI(b_clear),
    .InValidxSI(b_inv), .ExpxDI(b_exp), ._QxDI(b_q), .QxDO(b_qo),
    .OutValidxSO(b_ov), .MismatchxSO(b_mm), .ErrCntxDO(b_err), .ChkCntxDO(b_chk),
    .FirstErrIdxxDO(b_fei), .FirstErrValidxSO(b_fev), .BusyxSO(b_busy), .DonexSO(b_done)
  );

  dom_gf2_unmask_monitor #(.SHARES(3), .LATENCY(3), .NUM_VECTORS(2), .CNT_W(8)) u_c (
    .ClkxCI(clk), .RstxBI(rst_n), .StartxSI(c_start), .ClearxSI(c_clear),
    .InValidxSI(c_inv), .ExpxDI(c_exp), ._QxDI(c_q), .QxDO(c_qo),
    .OutValidxSO(c_ov), .MismatchxSO(c_mm), .ErrCntxDO(c_err), .ChkCntxDO(c_chk),
    .FirstErrIdxxDO(c_fei), .FirstErrValidxSO(c_fev), .BusyxSO(c_busy), .DonexSO(c_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {a_start, a_clear, a_inv, a_exp, a_q} = '0;
    {b_start, b_clear, b_inv, b_exp, b_q} = '0;
    {c_start, c_clear, c_inv, c_exp, c_q} = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_a_qo",   32'(a_qo), 32'(0));
    check_eq("rst_a_ov",   32'(a_ov), 32'(0));
    check_eq("rst_a_chk",  32'(a_chk), 32'(0));
    check_eq("rst_a_busy", 32'(a_busy), 32'(0));
    check_eq("rst_a_done", 32'(a_done), 32'(0));
    rst_n = 1'b1;

    // A1: four matching vectors, shares 01^11 = 10
    a_start = 1'b1; tick(); a_start = 1'b0;
    check_eq("a1_busy", 32'(a_busy), 32'(1));
    for (int e = 0; e < 5; e++) begin
      a_inv = (e < 4);
      a_exp = 2'b10;
      a_q   = (e >= 1) ? 4'b1101 : 4'b0000;
      tick();
      check_eq("a1_ov", 32'(a_ov), 32'(e >= 1));
      if (e >= 1) begin
        check_eq("a1_qo", 32'(a_qo), 32'h2);
        check_eq("a1_mm", 32'(a_mm), 32'(0));
      end
    end
    a_inv = 1'b0;
    check_eq("a1_chk",  32'(a_chk), 32'(4));
    check_eq("a1_err",  32'(a_err), 32'(0));
    check_eq("a1_fev",  32'(a_fev), 32'(0));
    check_eq("a1_done", 32'(a_done), 32'(1));
    check_eq("a1_busy_end", 32'(a_busy), 32'(0));
    tick();
    check_eq("a1_ov_idle", 32'(a_ov), 32'(0));
    check_eq("a1_qo_hold", 32'(a_qo), 32'h2);
    check_eq("a1_done_hold", 32'(a_done), 32'(1));

    // A2: second vector recombines to 11 against golden 10
    a_start = 1'b1; tick(); a_start = 1'b0;
    check_eq("a2_chk0", 32'(a_chk), 32'(0));
    for (int e = 0; e < 5; e++) begin
      a_inv = (e < 4);
      a_exp = 2'b10;
      a_q   = (e == 2) ? 4'b1100 : ((e >= 1) ? 4'b1101 : 4'b0000);
      tick();
      check_eq("a2_ov", 32'(a_ov), 32'(e >= 1));
      check_eq("a2_mm", 32'(a_mm), 32'(e == 2));
      if (e == 2) check_eq("a2_qo", 32'(a_qo), 32'h3);
    end
    a_inv = 1'b0;
    check_eq("a2_err", 32'(a_err), 32'(1));
    check_eq("a2_fei", 32'(a_fei), 32'(1));
    check_eq("a2_fev", 32'(a_fev), 32'(1));
    check_eq("a2_chk", 32'(a_chk), 32'(4));

    // A3: clear together with start while a vector is in flight
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_inv = 1'b1; a_exp = 2'b10; a_q = 4'b0000; tick();
    a_q = 4'b1100; tick();
    check_eq("a3_err_pre", 32'(a_err), 32'(1));
    a_inv = 1'b0; a_clear = 1'b1; a_start = 1'b1; a_q = 4'b1101; tick();
    a_clear = 1'b0; a_start = 1'b0;
    check_eq("a3_ov",   32'(a_ov), 32'(0));
    check_eq("a3_busy", 32'(a_busy), 32'(0));
    check_eq("a3_done", 32'(a_done), 32'(0));
    check_eq("a3_chk",  32'(a_chk), 32'(0));
    check_eq("a3_err",  32'(a_err), 32'(0));
    check_eq("a3_fei",  32'(a_fei), 32'(0));
    check_eq("a3_fev",  32'(a_fev), 32'(0));
    tick();
    check_eq("a3_ov_flushed", 32'(a_ov), 32'(0));
    check_eq("a3_busy_idle",  32'(a_busy), 32'(0));

    // InValid while IDLE must not be accepted or delayed
    for (int e = 0; e < 4; e++) begin
      a_inv = (e < 3);
      a_q   = 4'b1100;
      tick();
      check_eq("idle_ov",  32'(a_ov), 32'(0));
      check_eq("idle_chk", 32'(a_chk), 32'(0));
    end
    a_inv = 1'b0;

    // B: every vector mismatches (01 vs 00), two runs
    b_exp = 2'b00; b_q = 4'b0001;
    for (int r = 0; r < 2; r++) begin
      b_start = 1'b1; tick(); b_start = 1'b0;
      check_eq("b_err_zeroed", 32'(b_err), 32'(0));
      check_eq("b_chk_zeroed", 32'(b_chk), 32'(0));
      for (int e = 0; e < 4; e++) begin
        b_inv = (e < 3);
        tick();
        check_eq("b_mm", 32'(b_mm), 32'(e >= 1));
      end
      b_inv = 1'b0;
      check_eq("b_err", 32'(b_err), 32'(3));
      check_eq("b_chk", 32'(b_chk), 32'(3));
      check_eq("b_fei", 32'(b_fei), 32'(0));
      check_eq("b_done", 32'(b_done), 32'(1));
    end
    b_inv = 1'b1; tick(); tick(); b_inv = 1'b0;
    check_eq("b_err_hold", 32'(b_err), 32'(3));
    check_eq("b_ov_done",  32'(b_ov), 32'(0));

    // C: LATENCY=3, InValid 1,0,1, three-share recombination
    c_start = 1'b1; tick(); c_start = 1'b0;
    for (int e = 0; e < 7; e++) begin
      c_inv = (e == 0) || (e == 2);
      c_exp = (e == 0) ? 2'b01 : ((e == 2) ? 2'b10 : 2'b11);
      c_q   = (e == 3) ? 6'b001011 : ((e == 5) ? 6'b001101 : 6'b111111);
      tick();
      check_eq("c_ov", 32'(c_ov), 32'((e == 3) || (e == 5)));
      check_eq("c_done", 32'(c_done), 32'(e >= 5));
      if (e == 3) check_eq("c_qo_v1", 32'(c_qo), 32'h1);
      if (e == 5) check_eq("c_qo_v2", 32'(c_qo), 32'h2);
      if ((e == 3) || (e == 5)) check_eq("c_mm", 32'(c_mm), 32'(0));
    end
    c_inv = 1'b0;
    check_eq("c_chk", 32'(c_chk), 32'(2));
    check_eq("c_err", 32'(c_err), 32'(0));

    // C: async reset in DRAIN
    c_start = 1'b1; tick(); c_start = 1'b0;
    c_inv = 1'b1; c_exp = 2'b01; tick();
    tick();
    c_inv = 1'b0; tick();
    c_q = 6'b001011; tick();
    check_eq("c_drain_busy", 32'(c_busy), 32'(1));
    check_eq("c_drain_ov",   32'(c_ov), 32'(1));
    check_eq("c_drain_chk",  32'(c_chk), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_c_qo",   32'(c_qo), 32'(0));
    check_eq("arst_c_ov",   32'(c_ov), 32'(0));
    check_eq("arst_c_chk",  32'(c_chk), 32'(0));
    check_eq("arst_c_busy", 32'(c_busy), 32'(0));
    check_eq("arst_c_done", 32'(c_done), 32'(0));
    check_eq("arst_a_qo",   32'(a_qo), 32'(0));
    check_eq("arst_b_err",  32'(b_err), 32'(0));
    check_eq("arst_b_done", 32'(b_done), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
